divider_8by4_seq: RTL

//  Sequential restoring divider. It is the inverse datapath of the 4x4 array multiplier.
//  It takes an 8-bit dividend (e.g. a multiplier Product) and a 4-bit divisor.
//  It returns quotient and remainder, resolving one bit per clock.

---
 rtl/divider_8by4_seq_if.sv | 25 ++
 rtl/divider_8by4_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/divider_8by4_seq_if.sv
// Handshake and operand/result bundle for the sequential 8-by-4 restoring divider.
// The master drives a request; the slave (divider) returns busy/done and registered results.
interface divider_8by4_seq_if #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
);
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_8by4_seq.sv
// Sequential restoring divider: DVD_W-bit dividend by DVS_W-bit divisor, one quotient bit per clock.
// Results and the divide-by-zero flag are registered and held until the next done pulse.
module divider_8by4_seq #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    divider_8by4_seq_if.slave      bus
);
    localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [DVD_W-1:0] r_q;
    logic [DVS_W-1:0] r_d;
    logic [DVS_W:0]   r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [DVD_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;

    // Shifted partial remainder carries one extra top bit so the trial compare never wraps.
    logic [DVS_W+1:0] w_rs;
    logic             w_ge;
    logic [DVS_W:0]   w_sub;
    logic [DVS_W:0]   w_r_new;
    logic [DVD_W-1:0] w_q_new;

    assign w_rs    = {r_r, r_q[DVD_W-1]};
    assign w_ge    = (w_rs >= {2'b00, r_d});
    assign w_sub   = w_rs[DVS_W:0] - {1'b0, r_d};
    assign w_r_new = w_ge ? w_sub : w_rs[DVS_W:0];
    assign w_q_new = {r_q[DVD_W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_q    <= bus.dividend;
                        r_d    <= bus.divisor;
                        r_r    <= '0;
                        r_cnt  <= CNT_W'(DVD_W - 1);
                        r_busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Zero divisor short-circuits straight to DONE with a saturated quotient.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= bus.dividend[DVS_W-1:0];
                            r_dz    <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_q   <= w_q_new;
                    r_r   <= w_r_new;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_quot  <= w_q_new;
                        r_rem   <= w_r_new[DVS_W-1:0];
                        r_dz    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dz;
endmodule
